alu_op_sequencer: RTL and testbench

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

---
 rtl/alu_seq_pkg.sv | 28 ++
 rtl/seq_wait_cnt.sv | 37 +++
 rtl/alu_op_sequencer.sv | 118 +++++++++++
 tb/tb_alu_op_sequencer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operation sequencer.
// Holds the FSM state encoding, instruction field positions and the default EXEC length.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } seq_state_e;

    localparam int unsigned INSTR_W         = 16;
    localparam int unsigned FIELD_W         = 4;
    localparam int unsigned OPC_LSB         = 12;
    localparam int unsigned RD_LSB          = 8;
    localparam int unsigned RS1_LSB         = 4;
    localparam int unsigned RS2_LSB         = 0;
    localparam int unsigned EXEC_CYCLES_DEF = 1;
    localparam int unsigned WAIT_CNT_W      = 4;

    function automatic logic [FIELD_W-1:0] instr_field(
        input logic [INSTR_W-1:0] ins,
        input int unsigned        lsb
    );
        return ins[lsb +: FIELD_W];
    endfunction

endpackage

// File: rtl/seq_wait_cnt.sv
// Loadable down-counter that times the EXEC phase; done_o is high while the count is zero.
module seq_wait_cnt
    import alu_seq_pkg::*;
#(
    parameter int unsigned CNT_W = WAIT_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saturates at zero so a stalled or lingering EXEC never underflows.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/alu_op_sequencer.sv
// Single-issue IDLE/READ/EXEC/WB sequencer between a requester, a register bank and an ALU.
// Define ALU_SEQ_RETIRE_CNT_EN to build the retired-writeback counter; otherwise retire_cnt is 0.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned EXEC_CYCLES = EXEC_CYCLES_DEF,
    parameter int unsigned DATA_W      = 32
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic              step_en,
    input  logic              instr_valid,
    input  logic [15:0]       instr,
    output logic              instr_ready,
    output logic [3:0]        rf_rd_addr,
    output logic [3:0]        rf_rs1_addr,
    output logic [3:0]        rf_rs2_addr,
    output logic              rf_we,
    output logic [3:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    output logic              busy,
    output logic [31:0]       retire_cnt
);

    seq_state_e        state_q, state_d;
    logic [15:0]       instr_q;
    logic [DATA_W-1:0] result_q;
    logic              result_valid_q;
    logic              exec_done;
    logic              accept;
    logic              wb_fire;

    assign accept  = instr_valid && instr_ready && step_en;
    assign wb_fire = (state_q == ST_WB) && step_en;

    seq_wait_cnt #(
        .CNT_W (WAIT_CNT_W)
    ) u_wait_cnt (
        .clk_i      (CLK),
        .rst_i      (rst),
        .en_i       (step_en && ((state_q == ST_READ) || (state_q == ST_EXEC))),
        .load_i     (state_q == ST_READ),
        .load_val_i (WAIT_CNT_W'(EXEC_CYCLES - 1)),
        .done_o     (exec_done)
    );

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else if (step_en) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (instr_valid) state_d = ST_READ;
            ST_READ: state_d = ST_EXEC;
            ST_EXEC: if (exec_done) state_d = ST_WB;
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // rst gates the strobes combinationally so an abort in WB never writes.
    always_comb begin
        instr_ready = (state_q == ST_IDLE) && !rst;
        rf_we       = (state_q == ST_WB) && !rst;
        busy        = (state_q != ST_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            instr_q <= '0;
        end else if (accept) begin
            instr_q <= instr;
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            result_valid_q <= wb_fire;
            if (wb_fire) begin
                result_q <= alu_result;
            end
        end
    end

    assign alu_op       = instr_field(instr_q, OPC_LSB);
    assign rf_rd_addr   = instr_field(instr_q, RD_LSB);
    assign rf_rs1_addr  = instr_field(instr_q, RS1_LSB);
    assign rf_rs2_addr  = instr_field(instr_q, RS2_LSB);
    assign result       = result_q;
    assign result_valid = result_valid_q;

`ifdef ALU_SEQ_RETIRE_CNT_EN
    logic [31:0] retire_q;

    always_ff @(posedge CLK) begin
        if (rst) begin
            retire_q <= '0;
        end else if (wb_fire) begin
            retire_q <= retire_q + 32'd1;
        end
    end

    assign retire_cnt = retire_q;
`else
    assign retire_cnt = '0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized scoreboard bench for alu_op_sequencer with a latency-level reference model.
module tb_alu_op_sequencer;

    localparam int EC = 4;
    localparam int DW = 32;

    logic          CLK = 1'b0;
    logic          rst;
    logic          step_en;
    logic          instr_valid;
    logic [15:0]   instr;
    logic          instr_ready;
    logic [3:0]    rf_rd_addr, rf_rs1_addr, rf_rs2_addr;
    logic          rf_we;
    logic [3:0]    alu_op;
    logic [DW-1:0] alu_result;
    logic [DW-1:0] result;
    logic          result_valid;
    logic          busy;
    logic [31:0]   retire_cnt;

    always #5 CLK = ~CLK;

    alu_op_sequencer #(
        .EXEC_CYCLES (EC),
        .DATA_W      (DW)
    ) dut (
        .CLK          (CLK),
        .rst          (rst),
        .step_en      (step_en),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .instr_ready  (instr_ready),
        .rf_rd_addr   (rf_rd_addr),
        .rf_rs1_addr  (rf_rs1_addr),
        .rf_rs2_addr  (rf_rs2_addr),
        .rf_we        (rf_we),
        .alu_op       (alu_op),
        .alu_result   (alu_result),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy),
        .retire_cnt   (retire_cnt)
    );

    function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd0:    return a ^ b;
            4'd1:    return a - b;
            4'd2:    return a + b;
            4'd3:    return a & b;
            4'd4:    return a | b;
            4'd5:    return a << b[4:0];
            4'd6:    return a >> b[4:0];
            default: return a + b + {28'd0, op};
        endcase
    endfunction

    // Bench-side register bank and ALU that the DUT drives.
    logic [31:0] bank [16];
    logic [31:0] init_vals [16];
    logic        bank_load;

    assign alu_result = alu_f(alu_op, bank[rf_rs1_addr], bank[rf_rs2_addr]);

    always @(posedge CLK) begin
        if (bank_load) begin
            for (int i = 0; i < 16; i++) bank[i] <= init_vals[i];
        end else if (rf_we && step_en) begin
            bank[rf_rd_addr] <= alu_result;
        end
    end

    // Reference model: one transaction in flight, timed in enabled cycles.
    typedef struct {
        logic [31:0] val;
        int          tgt;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] mregs [16];
    logic        m_out, m_vld;
    int          m_age, ecnt;
    logic [15:0] m_last;
    logic [31:0] m_res, m_ret, p_val;
    logic [3:0]  p_rd;
    logic        chk_en;
    int          n_cmp, n_bad;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick(input logic v, input logic [15:0] ins, input logic st, input logic r, output logic acc);
        instr_valid = v;
        instr       = ins;
        step_en     = st;
        rst         = r;
        acc         = v && !m_out && st && !r;
        @(posedge CLK);
        if (r) begin
            m_out = 1'b0; m_age = 0; m_last = '0; m_res = '0; m_vld = 1'b0; m_ret = '0;
            sbq.delete();
        end else begin
            m_vld = 1'b0;
            if (st) begin
                ecnt++;
                if (m_out) begin
                    m_age++;
                    if (m_age == EC + 2) begin
                        m_out = 1'b0;
                        mregs[p_rd] = p_val;
                        m_res = p_val;
                        m_vld = 1'b1;
                        m_ret = m_ret + 32'd1;
                    end
                end
                if (acc) begin
                    m_out  = 1'b1;
                    m_age  = 0;
                    m_last = ins;
                    p_rd   = ins[11:8];
                    p_val  = alu_f(ins[15:12], mregs[ins[7:4]], mregs[ins[3:0]]);
                    sbq.push_back('{val: p_val, tgt: ecnt + EC + 2});
                end
            end
        end
        #1;
    endtask

    task automatic submit(input logic [15:0] ins);
        logic a;
        a = 1'b0;
        for (int n = 0; n < 200 && !a; n++) tick(1'b1, ins, 1'b1, 1'b0, a);
    endtask

    task automatic idle_ticks(input int n, input logic st);
        logic a;
        for (int i = 0; i < n; i++) tick(1'b0, 16'h0, st, 1'b0, a);
    endtask

    task automatic drain();
        logic a;
        for (int n = 0; n < 100 && m_out; n++) tick(1'b0, 16'h0, 1'b1, 1'b0, a);
        tick(1'b0, 16'h0, 1'b1, 1'b0, a);
    endtask

    task automatic run_to_wb();
        logic a;
        for (int n = 0; n < 100 && m_out && m_age != EC + 1; n++) tick(1'b0, 16'h0, 1'b1, 1'b0, a);
    endtask

    // Per-cycle output checks against the model.
    always @(negedge CLK) begin
        if (chk_en) begin
            chk("instr_ready", 64'(instr_ready), 64'(!m_out && !rst));
            chk("busy", 64'(busy), 64'(m_out));
            chk("rf_we", 64'(rf_we), 64'(m_out && (m_age == EC + 1) && !rst));
            chk("result_valid", 64'(result_valid), 64'(m_vld));
            chk("result", 64'(result), 64'(m_res));
            chk("alu_op", 64'(alu_op), 64'(m_last[15:12]));
            chk("rd_addr", 64'(rf_rd_addr), 64'(m_last[11:8]));
            chk("rs1_addr", 64'(rf_rs1_addr), 64'(m_last[7:4]));
            chk("rs2_addr", 64'(rf_rs2_addr), 64'(m_last[3:0]));
`ifdef ALU_SEQ_RETIRE_CNT_EN
            chk("retire_cnt", 64'(retire_cnt), 64'(m_ret));
`else
            chk("retire_cnt", 64'(retire_cnt), 64'(0));
`endif
        end
    end

    // Scoreboard monitor: pops one expected writeback per result_valid pulse.
    always @(negedge CLK) begin
        if (chk_en && result_valid) begin
            if (sbq.size() == 0) begin
                chk("sb_pending", 64'(sbq.size()), 64'(1));
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("sb_result", 64'(result), 64'(e.val));
                chk("sb_latency", 64'(ecnt), 64'(e.tgt));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

    initial begin
        logic        a, pend, st, r;
        logic [15:0] cur;
        n_cmp = 0; n_bad = 0; chk_en = 1'b0; bank_load = 1'b1;
        m_out = 1'b0; m_vld = 1'b0; m_age = 0; ecnt = 0; m_last = '0; m_res = '0; m_ret = '0;
        p_val = '0; p_rd = '0;
        for (int i = 0; i < 16; i++) init_vals[i] = $urandom;
        init_vals[1] = 32'd2;
        init_vals[2] = 32'd3;
        for (int i = 0; i < 16; i++) mregs[i] = init_vals[i];

        tick(1'b1, 16'h2312, 1'b1, 1'b1, a);
        chk_en = 1'b1;
        tick(1'b1, 16'h2312, 1'b1, 1'b1, a);
        tick(1'b0, 16'h0, 1'b0, 1'b1, a);
        bank_load = 1'b0;
        idle_ticks(2, 1'b1);

        // Directed: 2+3 into r3, then rd aliasing rs1.
        submit(16'h2312);
        drain();
        submit(16'h2112);
        drain();

        // Back-to-back with valid held high.
        submit(16'($urandom));
        submit(16'($urandom));
        drain();

        // Three-cycle stall in EXEC.
        submit(16'($urandom));
        idle_ticks(2, 1'b1);
        idle_ticks(3, 1'b0);
        drain();

        // Stall in WB and in the result_valid cycle.
        submit(16'($urandom));
        run_to_wb();
        idle_ticks(2, 1'b0);
        idle_ticks(1, 1'b1);
        idle_ticks(2, 1'b0);
        idle_ticks(1, 1'b1);

        // Reset aborts in EXEC and in WB.
        submit(16'($urandom));
        idle_ticks(2, 1'b1);
        tick(1'b0, 16'h0, 1'b1, 1'b1, a);
        idle_ticks(2, 1'b1);
        submit(16'($urandom));
        run_to_wb();
        tick(1'b0, 16'h0, 1'b0, 1'b1, a);
        idle_ticks(2, 1'b1);

        // Random traffic with a holding requester.
        pend = 1'b0;
        cur  = '0;
        for (int c = 0; c < 3000; c++) begin
            if (!pend && ($urandom_range(0, 3) == 0)) begin
                cur  = 16'($urandom);
                pend = 1'b1;
            end
            st = ($urandom_range(0, 5) != 0);
            r  = ($urandom_range(0, 399) == 0);
            tick(pend, cur, st, r, a);
            if (a) pend = 1'b0;
        end
        drain();
        idle_ticks(2, 1'b1);
        chk("sb_leftover", 64'(sbq.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
